// File: rtl/library_share_arbiter_pkg.sv
// Shared definitions for the library mux+flop cell and its round-robin arbiter.
package library_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Pick the next owner; on a tie the requester that was not served last wins.
    function automatic arb_state_e arbitrate(input logic req_a, input logic req_b,
                                             input logic last_b);
        arb_state_e nxt;
        nxt = IDLE;
        if (req_a && req_b) begin
            nxt = last_b ? GNT_A : GNT_B;
        end else if (req_a) begin
            nxt = GNT_A;
        end else if (req_b) begin
            nxt = GNT_B;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/library_share_arbiter_if.sv
// Request/grant and cell-control signals between requesters, arbiter and shared cell.
interface library_share_arbiter_if;

    logic iReqA;
    logic iReqB;
    logic oGntA;
    logic oGntB;
    logic oSel;
    logic oEnb;
    logic oBusy;

    // Requester/harness side.
    modport master (
        output iReqA,
        output iReqB,
        input  oGntA,
        input  oGntB,
        input  oSel,
        input  oEnb,
        input  oBusy
    );

    // Arbiter side.
    modport slave (
        input  iReqA,
        input  iReqB,
        output oGntA,
        output oGntB,
        output oSel,
        output oEnb,
        output oBusy
    );

endinterface

// File: rtl/library_share_arbiter.sv
// Round-robin, time-boxed arbiter sharing one mux+enabled-flop cell between A and B,
// with a one-cycle turnaround so the select never moves under an active enable.
module library_share_arbiter
    import library_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned CNT_W       = 2
) (
    input  logic                    iClk,
    input  logic                    iClr,
    library_share_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             sel_q, sel_d;
    logic             enb_q, enb_d;
    logic             busy_q, busy_d;

    // State, counter, pointer and registered outputs.
    always_ff @(posedge iClk or negedge iClr) begin
        if (!iClr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            sel_q    <= SEL_A;
            enb_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            sel_q    <= sel_d;
            enb_q    <= enb_d;
            busy_q   <= busy_d;
        end
    end

    // Next state, hold counter and output decode of the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;

        case (state_q)
            IDLE, GAP: begin
                state_d = arbitrate(bus.iReqA, bus.iReqB, last_b_q);
            end
            GNT_A: begin
                if (cnt_q == HOLD_LAST || !bus.iReqA) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    last_b_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GNT_B: begin
                if (cnt_q == HOLD_LAST || !bus.iReqB) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    last_b_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        gnt_a_d = (state_d == GNT_A);
        gnt_b_d = (state_d == GNT_B);
        enb_d   = gnt_a_d | gnt_b_d;
        busy_d  = (state_d != IDLE);
        // Select only moves when entering a grant; it holds through GAP and IDLE.
        sel_d   = sel_q;
        if (gnt_a_d) begin
            sel_d = SEL_A;
        end else if (gnt_b_d) begin
            sel_d = SEL_B;
        end
    end

    assign bus.oGntA = gnt_a_q;
    assign bus.oGntB = gnt_b_q;
    assign bus.oSel  = sel_q;
    assign bus.oEnb  = enb_q;
    assign bus.oBusy = busy_q;

endmodule

// File: tb/tb_library_share_arbiter.sv
// Directed, table-driven bench for library_share_arbiter with per-cycle invariant checks.
module tb_library_share_arbiter;

    logic iClk = 1'b0;
    logic iClr;
    int   checks = 0;
    int   errors = 0;
    logic inv_en = 1'b0;
    logic prev_enb = 1'b0;
    logic prev_sel = 1'b0;

    library_share_arbiter_if u_if ();

    library_share_arbiter #(
        .HOLD_CYCLES(3),
        .CNT_W      (2)
    ) u_dut (
        .iClk(iClk),
        .iClr(iClr),
        .bus (u_if.slave)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic ra;
        logic rb;
        logic ga;
        logic gb;
        logic sel;
        logic sel_chk;
        logic enb;
        logic busy;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle invariants sampled away from the active edge.
    always @(negedge iClk) begin
        if (inv_en) begin
            chk("grant_exclusive", u_if.oGntA & u_if.oGntB, 1'b0);
            chk("enb_is_grant", u_if.oEnb, u_if.oGntA | u_if.oGntB);
            if (prev_enb && u_if.oEnb) begin
                chk("sel_stable_under_enb", u_if.oSel, prev_sel);
            end
            prev_enb = u_if.oEnb;
            prev_sel = u_if.oSel;
        end
    end

    initial begin
        // ra rb | ga gb sel sel_chk enb busy ; expected after the edge
        vecs[0]  = '{1,1, 1,0,0,1,1,1};  // tie from reset: A first
        vecs[1]  = '{1,1, 1,0,0,1,1,1};
        vecs[2]  = '{1,1, 1,0,0,1,1,1};
        vecs[3]  = '{1,1, 0,0,0,1,0,1};  // GAP after 3 cycles
        vecs[4]  = '{1,1, 0,1,1,1,1,1};  // B's turn
        vecs[5]  = '{1,1, 0,1,1,1,1,1};
        vecs[6]  = '{1,1, 0,1,1,1,1,1};
        vecs[7]  = '{1,1, 0,0,1,1,0,1};  // GAP holds sel=1
        vecs[8]  = '{1,1, 1,0,0,1,1,1};  // back to A
        vecs[9]  = '{1,1, 1,0,0,1,1,1};
        vecs[10] = '{1,1, 1,0,0,1,1,1};
        vecs[11] = '{0,0, 0,0,0,1,0,1};
        vecs[12] = '{0,0, 0,0,0,1,0,0};  // IDLE
        vecs[13] = '{1,0, 1,0,0,1,1,1};  // A alone
        vecs[14] = '{0,0, 0,0,0,1,0,1};  // early release -> GAP
        vecs[15] = '{0,0, 0,0,0,1,0,0};  // IDLE
        vecs[16] = '{0,1, 0,1,1,1,1,1};  // lone B: B,B,B,gap,B,B,B,gap,B,B
        vecs[17] = '{0,1, 0,1,1,1,1,1};
        vecs[18] = '{0,1, 0,1,1,1,1,1};
        vecs[19] = '{0,1, 0,0,1,1,0,1};
        vecs[20] = '{0,1, 0,1,1,1,1,1};
        vecs[21] = '{0,1, 0,1,1,1,1,1};
        vecs[22] = '{0,1, 0,1,1,1,1,1};
        vecs[23] = '{0,1, 0,0,1,1,0,1};
        vecs[24] = '{0,1, 0,1,1,1,1,1};
        vecs[25] = '{0,1, 0,1,1,1,1,1};
        vecs[26] = '{0,0, 0,0,1,1,0,1};  // B releases early
        vecs[27] = '{0,0, 0,0,1,0,0,0};  // IDLE
        vecs[28] = '{0,1, 0,1,1,1,1,1};  // B grant, cycle 1
        vecs[29] = '{0,1, 0,1,1,1,1,1};  // B grant, cycle 2

        // Reset held with both requests high: everything stays low.
        iClr = 1'b0;
        u_if.iReqA = 1'b1;
        u_if.iReqB = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        chk("rst_gnt_a", u_if.oGntA, 1'b0);
        chk("rst_gnt_b", u_if.oGntB, 1'b0);
        chk("rst_sel",   u_if.oSel,  1'b0);
        chk("rst_enb",   u_if.oEnb,  1'b0);
        chk("rst_busy",  u_if.oBusy, 1'b0);
        iClr = 1'b1;
        inv_en = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            u_if.iReqA = vecs[i].ra;
            u_if.iReqB = vecs[i].rb;
            @(posedge iClk);
            #1;
            chk($sformatf("v%0d_gnt_a", i), u_if.oGntA, vecs[i].ga);
            chk($sformatf("v%0d_gnt_b", i), u_if.oGntB, vecs[i].gb);
            chk($sformatf("v%0d_enb", i),   u_if.oEnb,  vecs[i].enb);
            chk($sformatf("v%0d_busy", i),  u_if.oBusy, vecs[i].busy);
            if (vecs[i].sel_chk) begin
                chk($sformatf("v%0d_sel", i), u_if.oSel, vecs[i].sel);
            end
        end

        // Reset mid-grant (2nd cycle of GNT_B): outputs drop without a clock edge.
        #3;
        iClr = 1'b0;
        #1;
        chk("midrst_gnt_b", u_if.oGntB, 1'b0);
        chk("midrst_enb",   u_if.oEnb,  1'b0);
        chk("midrst_busy",  u_if.oBusy, 1'b0);
        u_if.iReqA = 1'b1;
        u_if.iReqB = 1'b1;
        @(posedge iClk);
        #1;
        chk("midrst_held_gnt_a", u_if.oGntA, 1'b0);
        chk("midrst_held_busy",  u_if.oBusy, 1'b0);
        iClr = 1'b1;
        @(posedge iClk);
        #1;
        chk("post_rst_gnt_a", u_if.oGntA, 1'b1);
        chk("post_rst_gnt_b", u_if.oGntB, 1'b0);
        chk("post_rst_sel",   u_if.oSel,  1'b0);
        chk("post_rst_enb",   u_if.oEnb,  1'b1);
        @(posedge iClk);
        #1;
        chk("post_rst_gnt_a2", u_if.oGntA, 1'b1);

        inv_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
